// File: rtl/bcd_updown_counter_n.sv
// Multi-digit packed-BCD up/down counter.
// Every digit steps in the same edge: carry/borrow is a combinational
// prefix of "all lower digits are 9" / "all lower digits are 0", so there
// is no ripple latency. Parallel load replaces out-of-range digits by 0
// and flags it. WRAP selects wrap-around or saturation at the range limits.
module bcd_updown_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  stepclk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  updown,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt_out,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  ovf,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] cnt_q;
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] load_clean;
  logic                load_bad;
  logic [DIGITS:0]     low_all9;
  logic [DIGITS:0]     low_all0;
  logic                at_limit;

  // Prefix chains: low_all9[i] means digits 0..i-1 are all 9 (likewise for 0).
  always_comb begin
    low_all9[0] = 1'b1;
    low_all0[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      low_all9[i+1] = low_all9[i] & (cnt_q[4*i +: 4] == 4'd9);
      low_all0[i+1] = low_all0[i] & (cnt_q[4*i +: 4] == 4'd0);
    end
  end

  assign at_max  = low_all9[DIGITS];
  assign at_zero = low_all0[DIGITS];

  // A step that would cross the range limit in the current direction.
  assign at_limit = updown ? at_zero : at_max;

  // Next count for one step; the natural 9->0 / 0->9 digit rollover gives wrap.
  always_comb begin
    step_val = cnt_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (!updown) begin
        if (low_all9[i]) begin
          step_val[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
        end
      end else begin
        if (low_all0[i]) begin
          step_val[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd0) ? 4'd9 : cnt_q[4*i +: 4] - 4'd1;
        end
      end
    end
  end

  // Sanitise the load value: digits above 9 become 0 and raise load_bad.
  always_comb begin
    load_clean = load_val;
    load_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd0;
        load_bad             = 1'b1;
      end
    end
  end

  // Count register and one-cycle status pulses; priority reset > load > en > hold.
  always_ff @(posedge stepclk) begin
    if (!reset) begin
      cnt_q    <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      cnt_q    <= load_clean;
      ovf      <= 1'b0;
      load_err <= load_bad;
    end else if (en) begin
      if (!(at_limit && !WRAP)) begin
        cnt_q <= step_val;
      end
      ovf      <= at_limit;
      load_err <= 1'b0;
    end else begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end
  end

  assign cnt_out = cnt_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench for bcd_updown_counter_n: a wrapping and a saturating
// instance share the same stimulus; expected values are hand-computed.
module tb_bcd_updown_counter_n;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  // Clock / reset and shared stimulus
  logic         stepclk = 1'b0;
  logic         reset   = 1'b0;
  logic         en      = 1'b0;
  logic         updown  = 1'b0;
  logic         load    = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] w_cnt, s_cnt;
  logic         w_max, w_zero, w_ovf, w_err;
  logic         s_max, s_zero, s_ovf, s_err;

  int errors = 0;
  int checks = 0;

  always #5 stepclk = ~stepclk;

  bcd_updown_counter_n #(.DIGITS(DIGITS), .WRAP(1'b1)) u_wrap (
    .stepclk (stepclk),
    .reset   (reset),
    .en      (en),
    .updown  (updown),
    .load    (load),
    .load_val(load_val),
    .cnt_out (w_cnt),
    .at_max  (w_max),
    .at_zero (w_zero),
    .ovf     (w_ovf),
    .load_err(w_err)
  );

  bcd_updown_counter_n #(.DIGITS(DIGITS), .WRAP(1'b0)) u_sat (
    .stepclk (stepclk),
    .reset   (reset),
    .en      (en),
    .updown  (updown),
    .load    (load),
    .load_val(load_val),
    .cnt_out (s_cnt),
    .at_max  (s_max),
    .at_zero (s_zero),
    .ovf     (s_ovf),
    .load_err(s_err)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs change only after this
  task automatic tick();
    @(posedge stepclk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    en       = 1'b0;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    tick();
    check("rst_cnt",  32'(w_cnt), 32'h0000);
    check("rst_zero", 32'(w_zero), 32'd1);
    check("rst_max",  32'(w_max), 32'd0);
    check("rst_ovf",  32'(w_ovf), 32'd0);
    check("rst_err",  32'(w_err), 32'd0);
    check("rst_scnt", 32'(s_cnt), 32'h0000);

    // Up-count 10 steps: 0x0009 then carry into 0x0010
    reset  = 1'b1;
    en     = 1'b1;
    updown = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) check("up1", 32'(w_cnt), 32'h0001);
      if (i == 9) check("up9", 32'(w_cnt), 32'h0009);
    end
    check("up10",     32'(w_cnt), 32'h0010);
    check("up10_ovf", 32'(w_ovf), 32'd0);
    check("up10_zero", 32'(w_zero), 32'd0);

    // Wrap at the top, then wrap at the bottom
    do_load(16'h9998);
    check("ld9998",     32'(w_cnt), 32'h9998);
    check("ld9998_err", 32'(w_err), 32'd0);
    en = 1'b1; updown = 1'b0;
    tick();
    check("to9999",     32'(w_cnt), 32'h9999);
    check("to9999_max", 32'(w_max), 32'd1);
    check("to9999_ovf", 32'(w_ovf), 32'd0);
    tick();
    check("wrap_up",      32'(w_cnt), 32'h0000);
    check("wrap_up_ovf",  32'(w_ovf), 32'd1);
    check("wrap_up_zero", 32'(w_zero), 32'd1);
    check("sat_up",       32'(s_cnt), 32'h9999);
    check("sat_up_ovf",   32'(s_ovf), 32'd1);
    updown = 1'b1;
    tick();
    check("wrap_dn",     32'(w_cnt), 32'h9999);
    check("wrap_dn_ovf", 32'(w_ovf), 32'd1);
    check("sat_dn9998",  32'(s_cnt), 32'h9998);
    check("sat_dn_ovf0", 32'(s_ovf), 32'd0);

    // Saturation at the top: three blocked steps
    do_load(16'h9999);
    en = 1'b1; updown = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_hold_max", 32'(s_cnt), 32'h9999);
      check("sat_hold_ovf", 32'(s_ovf), 32'd1);
    end
    check("wrap_after3", 32'(w_cnt), 32'h0002);
    check("wrap_after3_ovf", 32'(w_ovf), 32'd0);

    // Saturation at the bottom
    do_load(16'h0000);
    en = 1'b1; updown = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("sat_hold_zero", 32'(s_cnt), 32'h0000);
      check("sat_zero_ovf",  32'(s_ovf), 32'd1);
    end

    // Load validation
    do_load(16'h12A4);
    check("ld_12a4",     32'(w_cnt), 32'h1204);
    check("ld_12a4_err", 32'(w_err), 32'd1);
    do_load(16'h0500);
    check("ld_0500",     32'(w_cnt), 32'h0500);
    check("ld_0500_err", 32'(w_err), 32'd0);
    do_load(16'hFAF3);
    check("ld_fafx",     32'(w_cnt), 32'h0003);
    check("ld_fafx_err", 32'(w_err), 32'd1);
    en = 1'b0;
    tick();
    check("err_pulse_end", 32'(w_err), 32'd0);

    // Load beats en; reset beats load
    do_load(16'h0100);
    load = 1'b1; en = 1'b1; updown = 1'b1; load_val = 16'h0042;
    tick();
    check("prio_load", 32'(w_cnt), 32'h0042);
    check("prio_ovf",  32'(w_ovf), 32'd0);
    reset = 1'b0;
    tick();
    check("prio_rst", 32'(w_cnt), 32'h0000);
    reset = 1'b1; load = 1'b0; en = 1'b1; updown = 1'b0;
    tick();
    check("resume", 32'(w_cnt), 32'h0001);

    // Carry and borrow cascades, then hold
    do_load(16'h0199);
    en = 1'b1; updown = 1'b0;
    tick();
    check("carry_0200", 32'(w_cnt), 32'h0200);
    do_load(16'h1000);
    en = 1'b1; updown = 1'b1;
    tick();
    check("borrow_0999", 32'(w_cnt), 32'h0999);
    check("borrow_ovf",  32'(w_ovf), 32'd0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_cnt", 32'(w_cnt), 32'h0999);
      check("hold_ovf", 32'(w_ovf), 32'd0);
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
